// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-wide RAM/IO port arbiter.
package mem_arbiter_pkg;

    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam logic [7:0]  ZeroByte      = 8'h00;
    localparam logic        RstEnable     = 1'b0;   // reset asserted when rst is low
    localparam logic [31:0] IoBaseDefault = 32'h0003_0000;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

    function automatic logic [2:0] decode_len(input logic [2:0] code);
        case (code)
            LEN_BYTE: return LEN_BYTE;
            LEN_HALF: return LEN_HALF;
            default:  return LEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM/IO port between instruction fetch and
// data access, sequencing little-endian multi-byte transfers one byte per cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IoBaseDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        ex_pre_fail,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);

    arb_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_owner_q, if_owner_d;

    logic [31:0] cur_addr;
    logic [31:0] merged;
    logic        io_stall;

    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        if_owner_d  = if_owner_q;
        ram_wr      = 1'b0;
        if_done     = 1'b0;
        mem_done    = 1'b0;

        cur_addr = addr_q + {29'd0, cnt_q};
        ram_a    = cur_addr;
        io_stall = (cur_addr >= IO_BASE) && io_buffer_full;

        case (cnt_q[1:0])
            2'd0:    ram_dout = wdata_q[7:0];
            2'd1:    ram_dout = wdata_q[15:8];
            2'd2:    ram_dout = wdata_q[23:16];
            default: ram_dout = wdata_q[31:24];
        endcase

        // Byte returned this cycle belongs to the address issued one cycle earlier.
        merged = buf_q;
        case (cnt_q)
            3'd1:    merged[7:0]   = ram_din;
            3'd2:    merged[15:8]  = ram_din;
            3'd3:    merged[23:16] = ram_din;
            3'd4:    merged[31:24] = ram_din;
            default: merged        = buf_q;
        endcase

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d     = mem_addr;
                    len_d      = decode_len(mem_len);
                    wdata_d    = mem_wdata;
                    buf_d      = ZeroWord;
                    cnt_d      = 3'd0;
                    if_owner_d = 1'b0;
                    state_d    = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req && !ex_pre_fail) begin
                    addr_d     = if_addr;
                    len_d      = LEN_WORD;
                    buf_d      = ZeroWord;
                    cnt_d      = 3'd0;
                    if_owner_d = 1'b1;
                    state_d    = IF_RD;
                end
            end
            IF_RD: begin
                if (ex_pre_fail) begin
                    buf_d   = ZeroWord;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
                    if_inst_d = merged;
                    state_d   = DONE;
                end else begin
                    buf_d = merged;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            MEM_RD: begin
                if (cnt_q == len_q) begin
                    mem_rdata_d = merged;
                    state_d     = DONE;
                end else begin
                    buf_d = merged;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            MEM_WR: begin
                if (!io_stall) begin
                    ram_wr = 1'b1;
                    if (cnt_q == len_q - 3'd1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if_done  = if_owner_q;
                mem_done = !if_owner_q;
                cnt_d    = 3'd0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A frozen cycle must not write and must not count as the done cycle.
        if (!rdy) begin
            ram_wr   = 1'b0;
            if_done  = 1'b0;
            mem_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= ZeroWord;
            len_q       <= 3'd0;
            wdata_q     <= ZeroWord;
            buf_q       <= ZeroWord;
            if_inst_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
            if_owner_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            if_owner_q  <= if_owner_d;
        end
    end

endmodule
